// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: a Moore FSM that sequences fetch, decode, memory, ALU and branch steps.
// Optional build macro MC_CTRL_TRAP_EN routes unrecognized opcodes to a sticky TRAP state.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_e state_q, state_d;

    function automatic logic branch_take(input logic [2:0] f3, input logic zero, input logic lt);
        logic take;
        case (f3)
            3'b000:  take = zero;
            3'b001:  take = ~zero;
            3'b100:  take = lt;
            3'b101:  take = ~lt;
            default: take = 1'b0;
        endcase
        return take;
    endfunction

    // State register; reset abandons any access in flight by returning straight to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; every output defaults to 0 and each state raises only its own.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
`ifdef MC_CTRL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = branch_take(funct3, alu_zero, alu_lt);
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_FETCH;
`endif
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected state/outputs queued at drive time, checked mid-cycle.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lt, mem_ready;
    logic       mem_req, mem_write, ir_write, reg_write, pc_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [3:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;
    logic [17:0] exp_q[$];

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .pc_write(pc_write), .adr_src(adr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_op(alu_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output order: mem_req mem_write ir_write reg_write pc_write adr_src a[1:0] b[1:0] res[1:0] op[1:0]
    function automatic logic [13:0] model_out(input logic [3:0] st, input logic rdy, input logic take);
        logic [13:0] o;
        case (st)
            4'd0:    o = {1'b1, 1'b0, rdy,  1'b0, rdy,  1'b0, 2'b00, 2'b10, 2'b10, 2'b00};
            4'd1:    o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
            4'd2:    o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
            4'd3:    o = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
            4'd4:    o = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
            4'd5:    o = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
            4'd6:    o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10};
            4'd7:    o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10};
            4'd8:    o = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
            4'd9:    o = {1'b0, 1'b0, 1'b0, 1'b0, take, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01};
            4'd10:   o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
            default: o = 14'd0;
        endcase
        return o;
    endfunction

    // One cycle: drive inputs, queue expectation, compare at the falling edge, return just after the rising edge.
    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic lt, input logic rdy,
                        input logic [3:0] st, input logic take);
        logic [17:0] e;
        opcode    = op;
        funct3    = f3;
        alu_zero  = z;
        alu_lt    = lt;
        mem_ready = rdy;
        exp_q.push_back({st, model_out(st, rdy, take)});
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq({tag, ".state"}, {28'd0, state_dbg}, {28'd0, e[17:14]});
        check_eq({tag, ".outs"},
                 {18'd0, mem_req, mem_write, ir_write, reg_write, pc_write, adr_src,
                  alu_src_a, alu_src_b, result_src, alu_op},
                 {18'd0, e[13:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic go(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input logic lt, input logic [3:0] st, input logic take);
        step(tag, op, f3, z, lt, 1'b1, st, take);
    endtask

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    initial begin
        rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0;
        alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        step("rst_idle", LW, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;

        // Fetch stalls while memory is not ready
        step("fetch_wait", LW, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step("fetch_wait", LW, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // lw: 0,1,2,3,4
        go("lw", LW, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        go("lw", LW, 3'd2, 1'b0, 1'b0, 4'd1, 1'b0);
        go("lw", LW, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0);
        go("lw", LW, 3'd2, 1'b0, 1'b0, 4'd3, 1'b0);
        go("lw", LW, 3'd2, 1'b0, 1'b0, 4'd4, 1'b0);

        // sw with 3 wait cycles in MEMWRITE
        go("sw", SW, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        go("sw", SW, 3'd2, 1'b0, 1'b0, 4'd1, 1'b0);
        go("sw", SW, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) step("sw_wait", SW, 3'd2, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
        go("sw", SW, 3'd2, 1'b0, 1'b0, 4'd5, 1'b0);

        // Branch conditions: beq taken/not, bne, blt, bge, unsupported funct3
        go("beq_t", BR, 3'b000, 1'b1, 1'b0, 4'd0, 1'b0);
        go("beq_t", BR, 3'b000, 1'b1, 1'b0, 4'd1, 1'b0);
        go("beq_t", BR, 3'b000, 1'b1, 1'b0, 4'd9, 1'b1);
        go("beq_n", BR, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0);
        go("beq_n", BR, 3'b000, 1'b0, 1'b0, 4'd1, 1'b0);
        go("beq_n", BR, 3'b000, 1'b0, 1'b0, 4'd9, 1'b0);
        go("bne_t", BR, 3'b001, 1'b0, 1'b0, 4'd0, 1'b0);
        go("bne_t", BR, 3'b001, 1'b0, 1'b0, 4'd1, 1'b0);
        go("bne_t", BR, 3'b001, 1'b0, 1'b0, 4'd9, 1'b1);
        go("blt_t", BR, 3'b100, 1'b0, 1'b1, 4'd0, 1'b0);
        go("blt_t", BR, 3'b100, 1'b0, 1'b1, 4'd1, 1'b0);
        go("blt_t", BR, 3'b100, 1'b0, 1'b1, 4'd9, 1'b1);
        go("bge_n", BR, 3'b101, 1'b1, 1'b1, 4'd0, 1'b0);
        go("bge_n", BR, 3'b101, 1'b1, 1'b1, 4'd1, 1'b0);
        go("bge_n", BR, 3'b101, 1'b1, 1'b1, 4'd9, 1'b0);
        go("br_f010", BR, 3'b010, 1'b1, 1'b1, 4'd0, 1'b0);
        go("br_f010", BR, 3'b010, 1'b1, 1'b1, 4'd1, 1'b0);
        go("br_f010", BR, 3'b010, 1'b1, 1'b1, 4'd9, 1'b0);

        // R-type, I-type, jal
        go("add", RT, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        go("add", RT, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0);
        go("add", RT, 3'd0, 1'b0, 1'b0, 4'd6, 1'b0);
        go("add", RT, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0);
        go("addi", IT, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        go("addi", IT, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0);
        go("addi", IT, 3'd0, 1'b0, 1'b0, 4'd7, 1'b0);
        go("addi", IT, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0);
        go("jal", JL, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        go("jal", JL, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0);
        go("jal", JL, 3'd0, 1'b0, 1'b0, 4'd10, 1'b0);
        go("jal", JL, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0);

        // Unrecognized opcode
        go("bad", BAD, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        go("bad", BAD, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0);
`ifdef MC_CTRL_TRAP_EN
        for (int i = 0; i < 3; i++) go("trap", BAD, 3'd0, 1'b1, 1'b1, 4'd11, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("trap_rst", {28'd0, state_dbg}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif
        go("after_bad", LW, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Reset asserted between edges while MEMREAD waits on memory
        go("lw_rst", LW, 3'd2, 1'b0, 1'b0, 4'd1, 1'b0);
        go("lw_rst", LW, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0);
        step("lw_rst", LW, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {28'd0, state_dbg}, 32'd0);
        check_eq("rst_async_rw", {31'd0, reg_write}, 32'd0);
        step("rst_hold", LW, 3'd2, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        rst_n = 1'b1;
        go("rst_rel", LW, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        go("rst_rel", LW, 3'd2, 1'b0, 1'b0, 4'd1, 1'b0);

        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port opcode  input  7  instruction opcode from the instruction register.
REQ-004 SHALL have port funct3  input  3  instruction funct3, used for branch condition.
REQ-005 SHALL have ports alu_zero  input  1 and alu_lt  input  1, the ALU result-equals-zero and signed-less-than flags.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-007 SHALL have ports mem_req, mem_write, ir_write, reg_write, pc_write, adr_src  output  1 each.
REQ-008 SHALL have ports alu_src_a, alu_src_b, result_src, alu_op  output  2 each; alu_op feeds the ALU decoder (00 add, 01 branch, 10 funct-decoded).
REQ-009 SHALL have port state_dbg  output  4  current state encoding.

Function
REQ-010 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11.
REQ-011 SHALL drive every output not listed for a state to 0.
REQ-012 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_op=00; ir_write=1 and pc_write=1 only when mem_ready=1; stays in FETCH while mem_ready=0, else goes to DECODE.
REQ-013 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00; next state by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, any other->FETCH (or TRAP, see REQ-027).
REQ-014 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next MEMREAD if opcode=0000011, else MEMWRITE.
REQ-015 MEMREAD: mem_req=1, adr_src=1, result_src=00; waits until mem_ready=1, then MEMWB.
REQ-016 MEMWB: result_src=01, reg_write=1; next FETCH.
REQ-017 MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00; waits until mem_ready=1, then FETCH.
REQ-018 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; next ALUWB.
REQ-019 EXECI: alu_src_a=10, alu_src_b=01, alu_op=10; next ALUWB.
REQ-020 ALUWB: result_src=00, reg_write=1; next FETCH.
REQ-021 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write=take, where take is alu_zero for funct3=000, !alu_zero for 001, alu_lt for 100, !alu_lt for 101, 0 otherwise; next FETCH.
REQ-022 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; next ALUWB.
REQ-023 Memory waits SHALL hold all outputs stable for any number of mem_ready=0 cycles; mem_write SHALL assert for the whole MEMWRITE dwell.
REQ-024 Instruction latency with mem_ready tied high: lw 5 cycles, sw 4, R/I-type 4, branch 3, jal 4.
REQ-025 state_dbg SHALL equal the current state encoding.

Reset
REQ-026 rst_n=0 SHALL immediately force state FETCH, independent of clk; outputs then take FETCH values (mem_req=1, ir_write=pc_write=0 until mem_ready); reset mid-access abandons the access with no further write or write-back.

Configuration
REQ-027 Macro MC_CTRL_TRAP_EN: when defined, an unrecognized opcode in DECODE goes to TRAP, which holds all outputs at 0 and stays there until reset; when undefined, TRAP is unreachable and unrecognized opcodes return to FETCH as no-ops.

Verification
REQ-028 Reset with mem_ready=1, then lw (opcode 0000011) -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; result_src=01 there.
REQ-029 sw with mem_ready low for 3 cycles in MEMWRITE -> state_dbg=5 for 4 cycles, mem_write=1 throughout, then FETCH.
REQ-030 beq (funct3=000) with alu_zero=1 -> pc_write=1 in BRANCH; repeat with alu_zero=0 -> pc_write=0; blt with alu_lt=1 -> pc_write=1.
REQ-031 R-type add (0110011) -> alu_op=10 and alu_src_b=00 in EXECR, then reg_write=1 in ALUWB, 4 cycles total.
REQ-032 Opcode 1111111 -> FETCH after DECODE without the macro; state 11 with all outputs 0 until rst_n pulse with the macro.
REQ-033 rst_n asserted mid-MEMREAD between clock edges -> state_dbg=0 immediately, no reg_write in the following cycle.
